// File: rtl/csa_slice_sequencer.sv
// Multi-cycle WIDTH-bit adder that reuses one SLICE-bit carry-skip slice, rippling carry between passes.
// Optional build macro OVF_FLAG_EN adds a signed-overflow output (ovf).
module csa_slice_sequencer #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             busy
`ifdef OVF_FLAG_EN
    ,
    output logic             ovf
`endif
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NSLICE - 1);
    localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r, state_nxt_s;
    logic [IDXW-1:0]  idx_r;
    logic             carry_r;
    logic [WIDTH-1:0] a_q_r, b_q_r, sum_q_r, sum_r;
    logic             cout_r, in_ready_r, out_valid_r, busy_r;
    logic             accept_s, last_s;
    logic             in_ready_nxt_s, out_valid_nxt_s, busy_nxt_s;
    int               base_s;
    logic [SLICE-1:0] op_a_s, op_b_s;
    logic [SLICE:0]   slice_res_s;
    logic [WIDTH-1:0] sum_merge_s;

    // Ripple through the slice; when every bit propagates the carry-in skips straight to the output.
    function automatic logic [SLICE:0] skip_slice_add(input logic [SLICE-1:0] a,
                                                      input logic [SLICE-1:0] b,
                                                      input logic             cin);
        logic [SLICE-1:0] p;
        logic [SLICE-1:0] s;
        logic             c;
        p = a ^ b;
        c = cin;
        for (int i = 0; i < SLICE; i++) begin
            s[i] = p[i] ^ c;
            c    = (a[i] & b[i]) | (p[i] & c);
        end
        if (&p) begin
            c = cin;
        end else begin
            c = c;
        end
        return {c, s};
    endfunction

    // Shared slice datapath: select operands for the current index and merge the result.
    always_comb begin
        base_s      = int'(idx_r) * SLICE;
        op_a_s      = a_q_r[base_s +: SLICE];
        op_b_s      = b_q_r[base_s +: SLICE];
        slice_res_s = skip_slice_add(op_a_s, op_b_s, carry_r);
        sum_merge_s = sum_q_r;
        sum_merge_s[base_s +: SLICE] = slice_res_s[SLICE-1:0];
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid && in_ready_r) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (idx_r == IDX_LAST) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Output decode: handshake flags are registered, so they follow the next state.
    always_comb begin
        accept_s        = (state_r == IDLE) && in_valid && in_ready_r;
        last_s          = (state_r == RUN) && (idx_r == IDX_LAST);
        in_ready_nxt_s  = (state_nxt_s == IDLE);
        out_valid_nxt_s = (state_nxt_s == DONE);
        busy_nxt_s      = (state_nxt_s != IDLE);
    end

    // State, operand capture and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            idx_r       <= '0;
            carry_r     <= 1'b0;
            a_q_r       <= '0;
            b_q_r       <= '0;
            sum_q_r     <= '0;
            sum_r       <= '0;
            cout_r      <= 1'b0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            in_ready_r  <= in_ready_nxt_s;
            out_valid_r <= out_valid_nxt_s;
            busy_r      <= busy_nxt_s;
            if (accept_s) begin
                a_q_r   <= A;
                b_q_r   <= B;
                carry_r <= Cin;
                idx_r   <= '0;
            end else if (state_r == RUN) begin
                carry_r <= slice_res_s[SLICE];
                sum_q_r <= sum_merge_s;
                if (last_s) begin
                    idx_r  <= '0;
                    sum_r  <= sum_merge_s;
                    cout_r <= slice_res_s[SLICE];
                end else begin
                    idx_r <= idx_r + IDX_ONE;
                end
            end
        end
    end

`ifdef OVF_FLAG_EN
    logic ovf_r;
    logic c_into_msb_s;

    // Carry into the MSB is recovered from the MSB sum bit and its operand bits.
    always_comb begin
        c_into_msb_s = slice_res_s[SLICE-1] ^ op_a_s[SLICE-1] ^ op_b_s[SLICE-1];
    end

    // Overflow flag is captured together with the final slice.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_r <= 1'b0;
        end else if (last_s) begin
            ovf_r <= c_into_msb_s ^ slice_res_s[SLICE];
        end
    end

    assign ovf = ovf_r;
`endif

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign Sum       = sum_r;
    assign Cout      = cout_r;

endmodule

// File: tb/tb_csa_slice_sequencer.sv
// Randomized self-checking bench for csa_slice_sequencer against a plain-arithmetic reference.
// Define OVF_FLAG_EN to also check the overflow output.
module tb_csa_slice_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic        Cin;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] Sum;
    logic        Cout;
    logic        busy;
`ifdef OVF_FLAG_EN
    logic        ovf;
`endif

    int total_cnt = 0;
    int bad_cnt   = 0;

    always #5 clk = ~clk;

    csa_slice_sequencer #(.WIDTH(32), .SLICE(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Sum       (Sum),
        .Cout      (Cout),
        .busy      (busy)
`ifdef OVF_FLAG_EN
        ,
        .ovf       (ovf)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full transaction with garbage on the inputs while busy and a chosen backpressure length.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic c,
                          input int hold, input string tag);
        logic [32:0] ref_v;
        logic        ref_ovf;
        int          n;
        ref_v   = {1'b0, a} + {1'b0, b} + {32'd0, c};
        ref_ovf = (a[31] == b[31]) && (ref_v[31] != a[31]);
        n = 0;
        while (!in_ready && n < 10) begin
            step();
            n++;
        end
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        A = a; B = b; Cin = c; in_valid = 1'b1;
        step();
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        chk({tag, "_no_ready"}, 64'(in_ready), 64'd0);
        n = 0;
        while (!out_valid && n < 12) begin
            A = $urandom; B = $urandom; Cin = 1'($urandom); out_ready = 1'($urandom);
            step();
            n++;
        end
        chk({tag, "_latency"}, 64'(n), 64'd4);
        chk({tag, "_sum"}, 64'(Sum), 64'(ref_v[31:0]));
        chk({tag, "_cout"}, 64'(Cout), 64'(ref_v[32]));
`ifdef OVF_FLAG_EN
        chk({tag, "_ovf"}, 64'(ovf), 64'(ref_ovf));
`endif
        for (int i = 0; i < hold; i++) begin
            out_ready = 1'b0;
            step();
            chk({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
            chk({tag, "_hold_sum"}, 64'({Cout, Sum}), 64'(ref_v));
        end
        out_ready = 1'b1;
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk({tag, "_drop_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_keep_sum"}, 64'(Sum), 64'(ref_v[31:0]));
        chk({tag, "_idle_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int n;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        A = 32'd0; B = 32'd0; Cin = 1'b0;
        step();
        step();
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_sum", 64'({Cout, Sum}), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
`ifdef OVF_FLAG_EN
        chk("rst_ovf", 64'(ovf), 64'd0);
`endif
        rst_n = 1'b1;
        step();
        chk("rel_in_ready", 64'(in_ready), 64'd1);

        run_op(32'h12345678, 32'h87654321, 1'b0, 0, "basic");
        run_op(32'hFFFFFFFF, 32'h00000001, 1'b1, 1, "ripple");
        run_op(32'hAAAAAAAA, 32'h55555555, 1'b0, 0, "nocarry");
        run_op(32'h00000000, 32'hFFFFFFFF, 1'b1, 5, "wrap");
        run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 0, "ovf_pos");
        run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 0, "ovf_none");
        run_op(32'h80000000, 32'h80000000, 1'b0, 0, "ovf_neg");

        // Abort with reset while the third slice is pending.
        run_op(32'h12345678, 32'h87654321, 1'b0, 0, "pre_abort");
        n = 0;
        while (!in_ready && n < 10) begin
            step();
            n++;
        end
        A = 32'h0F0F0F0F; B = 32'h01010101; Cin = 1'b1; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        step();
        chk("abort_valid", 64'(out_valid), 64'd0);
        chk("abort_sum", 64'(Sum), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        step();
        run_op(32'hDEADBEEF, 32'h10203040, 1'b1, 2, "post_abort");

        for (int k = 0; k < 25; k++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = $urandom;
            if (k % 5 == 0) ra = 32'hFFFFFFFF;
            if (k % 7 == 0) rb = ~ra;
            run_op(ra, rb, 1'($urandom), int'($urandom_range(0, 3)), "rand");
        end

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
